// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: bit positions [7:1], encoder, and the decoder's syndrome.
package hamming_pkg;

  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D0 = 3;
  localparam int P4 = 4;
  localparam int D1 = 5;
  localparam int D2 = 6;
  localparam int D3 = 7;

  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_t;

  function automatic logic [7:1] hamming_encode(input logic [3:0] n);
    logic [7:1] c;
    c     = '0;
    c[D0] = n[0];
    c[D1] = n[1];
    c[D2] = n[2];
    c[D3] = n[3];
    c[P1] = n[0] ^ n[1] ^ n[3];
    c[P2] = n[0] ^ n[2] ^ n[3];
    c[P4] = n[1] ^ n[2] ^ n[3];
    return c;
  endfunction

  // Syndrome value equals the position of a single flipped bit, 0 when clean.
  function automatic logic [2:0] hamming_syndrome(input logic [7:1] d);
    return {d[4] ^ d[5] ^ d[6] ^ d[7],
            d[2] ^ d[3] ^ d[6] ^ d[7],
            d[1] ^ d[3] ^ d[5] ^ d[7]};
  endfunction

  // One-hot mask at a bit position; position 0 yields an all-zero mask.
  function automatic logic [7:1] pos_mask(input logic [2:0] pos);
    logic [7:1] m;
    m = '0;
    for (int i = 1; i <= 7; i++) begin
      m[i] = (pos == 3'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_cw_fifo.sv
// Generic DEPTH-entry FIFO for 7-bit codewords with registered count; dout shows the head entry.
module hamming_cw_fifo
  import hamming_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:1]               din,
  input  logic                     pop,
  output logic [7:1]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:1]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hamming_enc_tx.sv
// Hamming(7,4) encoder front-end: nibble handshake, optional one-shot bit flip, codeword FIFO.
//
// state      | meaning
// INJ_IDLE   | no injection pending; words are written clean
// INJ_ARMED  | pos_q holds a position to invert in the next accepted word
module hamming_enc_tx
  import hamming_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             cw_valid,
  output logic [7:1]       cw,
  input  logic             cw_ready,
  input  logic             inj_arm,
  input  logic [2:0]       inj_pos,
  output logic             inj_pending,
  output logic [CNT_W-1:0] sent_cnt
);

  inj_state_t              state;
  inj_state_t              state_nxt;
  logic [2:0]              pos_q;
  logic [2:0]              pos_nxt;
  logic [7:1]              inj_mask;
  logic                    accept;
  logic                    xfer;
  logic [7:1]              fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign in_ready = ~fifo_full;
  assign cw_valid = (fifo_count != '0);
  assign cw       = fifo_empty ? '0 : fifo_dout;
  assign accept   = in_valid & in_ready;
  assign xfer     = cw_valid & cw_ready;

  hamming_cw_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (hamming_encode(in_data) ^ inj_mask),
    .pop   (xfer),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INJ_IDLE;
      pos_q <= '0;
    end else begin
      state <= state_nxt;
      pos_q <= pos_nxt;
    end
  end

  // An accept always consumes the injection, including one armed in the same cycle.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_q;
    if (inj_arm) begin
      pos_nxt   = inj_pos;
      state_nxt = (inj_pos != 3'd0) ? INJ_ARMED : INJ_IDLE;
    end
    if (accept) begin
      state_nxt = INJ_IDLE;
    end
  end

  always_comb begin
    inj_pending = (state == INJ_ARMED);
    inj_mask    = '0;
    if (inj_arm) begin
      inj_mask = pos_mask(inj_pos);
    end else if (state == INJ_ARMED) begin
      inj_mask = pos_mask(pos_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt <= '0;
    end else if (xfer) begin
      sent_cnt <= sent_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hamming_enc_tx.md
# hamming_enc_tx

Upstream companion of the 7-bit Hamming decoder/corrector. The block accepts 4-bit data nibbles over a valid/ready handshake and encodes each one into a Hamming(7,4) codeword using the decoder's [7:1] bit-position convention. Codewords are buffered in a 4-entry FIFO and presented to the decoder's D/EN inputs. A one-shot single-bit error injector lets benches exercise the decoder's correction path.

## Interface
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2
- CNT_W, 16, width of the sent-codeword counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  nibble present
- in_data  in  4  data nibble N[3:0]
- in_ready  out  1  block can accept a nibble
- cw_valid  out  1  codeword present; drives decoder EN
- cw  out  7  codeword [7:1]; drives decoder D
- cw_ready  in  1  downstream consumes codeword
- inj_arm  in  1  one-cycle pulse: arm error injection
- inj_pos  in  3  bit position to flip (1..7); 0 disarms
- inj_pending  out  1  injection armed, not yet applied
- sent_cnt  out  CNT_W  codewords transferred on the output

## Operation
- Encoding, positions [7:1]:
  - cw[3]=N0, cw[5]=N1, cw[6]=N2, cw[7]=N3
  - cw[1]=N0^N1^N3, cw[2]=N0^N2^N3, cw[4]=N1^N2^N3
- Accept: in_valid & in_ready. The encoded word, XORed with the injection mask, is written at wr_ptr.
- Output: cw_valid = (count≠0). cw = mem[rd_ptr] when valid, else 7'b0.
- Transfer: cw_valid & cw_ready. rd_ptr advances and sent_cnt increments, wrapping from 2^CNT_W−1 to 0.
- Flow control: in_ready = (count<DEPTH). It is a registered-state function only, with no combinational path from cw_ready.
- Pointers: log2(DEPTH) bits, natural wrap. count is log2(DEPTH)+1 bits.
- Injector states: IDLE / ARMED (inj_pending=1). The armed position is held in a register.
  - inj_arm with inj_pos∈1..7 → ARMED with that position. Arming while ARMED overwrites the position.
  - inj_arm with inj_pos=0 → IDLE.
  - While ARMED, the next accepted nibble gets its cw[inj_pos] inverted. The injector then returns to IDLE.
  - If inj_arm and an accept occur in the same cycle, the new arm applies to that same word, and the injector ends in IDLE.
  - inj_arm while in_valid is low leaves the injector ARMED until the next accept.

## Timing
- Reset values: in_ready=1, cw_valid=0, cw=0, inj_pending=0, sent_cnt=0. Pointers, count and injector are cleared.
- Latency: nibble accepted at edge k → cw_valid=1 with its codeword after edge k (visible in cycle k+1).
- Full (count=DEPTH): in_ready=0. A nibble presented while full is not accepted and must be held by the source.
- Empty: cw_valid=0 and cw=0. cw_ready is ignored and sent_cnt is unchanged.
- Simultaneous accept and transfer: count unchanged and both pointers advance. This is legal at any count 1..DEPTH−1.
- At count=DEPTH a transfer frees a slot, but in_ready stays 0 in that cycle.
- Reset mid-operation: all buffered codewords are discarded and a pending injection is dropped. cw_valid falls asynchronously with rst.
- Output is stable under backpressure: cw and cw_valid hold while cw_valid & !cw_ready.

## Structure
- Package hamming_pkg contains:
  - position constants P1, P2, P4, D0..D3
  - the function hamming_encode(input [3:0]) → [7:1]
  - the default DEPTH
  - the decoder's syndrome function, added later for reuse
- Sub-module hamming_cw_fifo: a generic 7-bit, DEPTH-entry synchronous FIFO with push/pop, full/empty and count. Encoder, injector and counter live in the top.

## Test plan
- Encode sweep: push N=0..15 with cw_ready=1. Codewords must be error-free; N=4'b0100 → cw=7'b0101010 and N=4'b0000 → 7'b0000000. Feeding each codeword to the decoder gives Error=0. sent_cnt=16.
- Backpressure/full: cw_ready=0, push 5 nibbles. The first 4 are accepted, then in_ready=0 and the 5th is held. Raise cw_ready: output order is preserved and the 5th is accepted one cycle after the first transfer.
- Simultaneous push/pop at count=2 for 10 cycles: count stays 2, no loss or duplication, and sent_cnt increases by 10.
- Injection: arm inj_pos=4, then push N=4'b0100. Output is 7'b0100010, inj_pending clears, and the decoder restores 0101010 with Error=1. The next word is clean. inj_pos=0 disarms with no flip.
- Same-cycle arm+accept with inj_pos=7 on N=0: cw=7'b1000000 and inj_pending=0 afterwards.
- Reset with 3 words buffered and injection armed: all outputs return to their reset values immediately, and the following push produces a clean codeword.
